pcode_fill_engine: RTL

- Parametrised pattern-fill engine that writes a generated data pattern into NCH SRAM write ports over a valid/ready handshake.
- Runs after a start pulse and signals completion with a one-cycle done pulse.
- Successor to the fixed two-SRAM, fixed-length initializer. Adds runtime end address, selectable data modes, sequential or parallel channel ordering, and abort.
- Sits between the system controller and the per-SRAM write adapters.

---
 rtl/pcode_fill_engine.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pcode_fill_engine.sv
// ---------------------------------------------------------------------------
// pcode_fill_engine
//
// Purpose:
//   Writes a generated data pattern into NCH SRAM write ports. Each port uses
//   a valid/ready handshake. A start pulse launches a fill of addresses
//   0..last_addr on every channel. The channels are filled either all at once
//   (parallel=1) or one after another, 0..NCH-1 (parallel=0). Normal
//   completion gives a one-cycle done pulse. An abort returns to IDLE with no
//   done pulse.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   start       start request, sampled only in IDLE
//   abort       terminate the fill, sampled only in FILL
//   mode        data mode: 0 = addr*MULT, 1 = LFSR, 2 = fill_value, 3 = addr
//   fill_value  constant for mode 2; LFSR seed for mode 1
//   last_addr   inclusive final address written on every channel
//   parallel    1 = all channels at once, 0 = channels in order
//   busy        high while in FILL
//   done        one-cycle pulse on normal completion
//   wr_valid    per-channel write valid
//   wr_ready    per-channel write ready
//   wr_addr     packed addresses, channel k at [k*AW +: AW]
//   wr_data     packed data, channel k at [k*DW +: DW]
//
// Configuration:
//   PCODE_FILL_LFSR_EN  when defined, mode 1 uses a per-channel 32-bit Galois
//                       LFSR (polynomial 0x80200003). When undefined, no LFSR
//                       is built and mode 1 behaves exactly as mode 0.
// ---------------------------------------------------------------------------
module pcode_fill_engine #(
    parameter int NCH  = 2,
    parameter int AW   = 18,
    parameter int DW   = 32,
    parameter int MULT = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DW-1:0]     fill_value,
    input  logic [AW-1:0]     last_addr,
    input  logic              parallel,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    wr_valid,
    input  logic [NCH-1:0]    wr_ready,
    output logic [NCH*AW-1:0] wr_addr,
    output logic [NCH*DW-1:0] wr_data
);

    localparam int          CW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [DW-1:0] MULT_W = DW'(MULT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;

    // Configuration latched on the start edge.
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   fill_q, fill_d;
    logic [AW-1:0]   last_q, last_d;
    logic            par_q, par_d;

    // Per-channel progress: current address and a "last beat accepted" flag.
    // The flag ends the channel without ever incrementing past last_addr, so
    // a full-space fill (last_addr = 2^AW-1) cannot wrap back to 0.
    logic [AW-1:0]   addr_q [NCH];
    logic [AW-1:0]   addr_d [NCH];
    logic [NCH-1:0]  fin_q, fin_d;

    // Active channel in sequential mode.
    logic [CW-1:0]   ch_q, ch_d;

    logic [NCH-1:0]  valid;
    logic [NCH-1:0]  hs;

`ifdef PCODE_FILL_LFSR_EN
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    logic [31:0]     lfsr_q [NCH];
    logic [31:0]     lfsr_d [NCH];

    // Galois form: shift right and fold in the polynomial when a 1 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    // A seed of 0 would lock the LFSR at 0, so it is forced to 1.
    function automatic logic [31:0] lfsr_seed(input logic [DW-1:0] fv, input int k);
        logic [31:0] s;
        s = 32'(fv) ^ 32'(k);
        return (s == '0) ? 32'd1 : s;
    endfunction
`endif

    assign busy = (state_q == S_FILL);
    assign done = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Valid, address and data outputs
    // ------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default before any branch.
    // Without the defaults, a path that does not assign a signal would infer
    // a latch.
    always_comb begin
        valid   = '0;
        wr_addr = '0;
        wr_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (state_q == S_FILL) begin
                valid[k] = !fin_q[k] && (par_q || (ch_q == CW'(k)));
            end
            if (valid[k]) begin
                wr_addr[k*AW +: AW] = addr_q[k];
                case (mode_q)
                    2'd2:    wr_data[k*DW +: DW] = fill_q;
                    2'd3:    wr_data[k*DW +: DW] = DW'(addr_q[k]);
`ifdef PCODE_FILL_LFSR_EN
                    2'd1:    wr_data[k*DW +: DW] = DW'(lfsr_q[k]);
`endif
                    default: wr_data[k*DW +: DW] = DW'(addr_q[k]) * MULT_W;
                endcase
            end
        end
    end

    assign wr_valid = valid;
    assign hs       = valid & wr_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        last_d  = last_q;
        par_d   = par_q;
        addr_d  = addr_q;
        fin_d   = fin_q;
        ch_d    = ch_q;
`ifdef PCODE_FILL_LFSR_EN
        lfsr_d  = lfsr_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FILL;
                    mode_d  = mode;
                    fill_d  = fill_value;
                    last_d  = last_addr;
                    par_d   = parallel;
`ifdef PCODE_FILL_LFSR_EN
                    for (int k = 0; k < NCH; k++) begin
                        lfsr_d[k] = lfsr_seed(fill_value, k);
                    end
`endif
                end
            end

            S_FILL: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    for (int k = 0; k < NCH; k++) begin
                        if (hs[k]) begin
                            if (addr_q[k] == last_q) begin
                                fin_d[k] = 1'b1;
                                // In sequential mode only one channel can
                                // handshake, so this hands over with no bubble.
                                ch_d     = ch_q + CW'(1);
                            end else begin
                                addr_d[k] = addr_q[k] + AW'(1);
                            end
`ifdef PCODE_FILL_LFSR_EN
                            lfsr_d[k] = lfsr_step(lfsr_q[k]);
`endif
                        end
                    end
                    if (&fin_d) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // Whenever FILL is left (completion or abort), the counters return to
        // their reset image. A later start therefore always begins at address 0.
        if (state_d != S_FILL) begin
            for (int k = 0; k < NCH; k++) begin
                addr_d[k] = '0;
            end
            fin_d = '0;
            ch_d  = '0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together from values computed before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            fill_q  <= '0;
            last_q  <= '0;
            par_q   <= 1'b0;
            fin_q   <= '0;
            ch_q    <= '0;
            // NOTE: the per-channel arrays are small flop banks, not SRAM.
            // They are reset explicitly so that nothing leaves reset unknown.
            for (int k = 0; k < NCH; k++) begin
                addr_q[k] <= '0;
`ifdef PCODE_FILL_LFSR_EN
                lfsr_q[k] <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            last_q  <= last_d;
            par_q   <= par_d;
            fin_q   <= fin_d;
            ch_q    <= ch_d;
            for (int k = 0; k < NCH; k++) begin
                addr_q[k] <= addr_d[k];
`ifdef PCODE_FILL_LFSR_EN
                lfsr_q[k] <= lfsr_d[k];
`endif
            end
        end
    end

endmodule
